// File: rtl/tq_pkg.sv
// ============================================================================
// Module   : tq_pkg
// Purpose  : Shared types and helpers for the term-quantized MAC row.
// Options  : TQ_MAC_ROW_SATURATE_EN (saturating lane adds, see tq_mac_lane)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tq_pkg;

  localparam int TQ_EXP_W = 3;
  localparam int TQ_ACC_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } lane_state_e;

  function automatic int unsigned clamp_data_terms(input int unsigned dt,
                                                   input int unsigned num_terms);
    return (dt > num_terms) ? num_terms : dt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tq_mac_lane.sv
// ============================================================================
// Module   : tq_mac_lane
// Purpose  : One term-quantized MAC lane: budget-masked shift-accumulate over
//            a group of beats, then adds the external partial sum.
// Options  : TQ_MAC_ROW_SATURATE_EN - saturate per-beat and final adds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tq_mac_lane
  import tq_pkg::*;
#(
  parameter int NUM_TERMS = 8,
  parameter int EXP_W     = TQ_EXP_W,
  parameter int COE_W     = 8,
  parameter int ACC_W     = TQ_ACC_W,
  parameter int GS_W      = 5,
  parameter int GB_W      = 7,
  parameter int DT_W      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DT_W-1:0]               cfg_data_terms,
  input  logic [GS_W-1:0]               cfg_group_size,
  input  logic [GB_W-1:0]               cfg_group_budget,
  input  logic signed [COE_W-1:0]       coe_in,
  input  logic                          coe_load,
  input  logic signed [ACC_W-1:0]       acc_in,
  input  logic                          in_valid,
  input  logic [NUM_TERMS*EXP_W-1:0]    exp_in,
  input  logic [NUM_TERMS-1:0]          sign_in,
  output logic signed [ACC_W-1:0]       result,
  output logic                          result_valid
);

  // Wide enough to hold acc plus NUM_TERMS full-scale terms without overflow.
  localparam int SW = ACC_W + $clog2(NUM_TERMS + 1) + 1;

`ifdef TQ_MAC_ROW_SATURATE_EN
  localparam logic signed [SW-1:0] c_max = (SW'(1) <<< (ACC_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] c_min = -(SW'(1) <<< (ACC_W - 1));
`endif

  function automatic logic signed [ACC_W-1:0] fit(input logic signed [SW-1:0] v);
`ifdef TQ_MAC_ROW_SATURATE_EN
    if (v > c_max)      return ACC_W'(c_max);
    else if (v < c_min) return ACC_W'(c_min);
    else                return ACC_W'(v);
`else
    return ACC_W'(v);
`endif
  endfunction

  lane_state_e              r_state;
  logic signed [COE_W-1:0]  r_coe;
  logic signed [ACC_W-1:0]  r_acc;
  logic [GS_W-1:0]          r_beat;
  logic [GB_W-1:0]          r_used;
  logic [DT_W-1:0]          r_dt;
  logic [GS_W-1:0]          r_gs;
  logic [GB_W-1:0]          r_gb;

  logic                     w_idle;
  logic [DT_W-1:0]          w_dt;
  logic [GS_W-1:0]          w_gs;
  logic [GB_W-1:0]          w_gb;
  logic [GB_W-1:0]          w_used;
  logic [GB_W-1:0]          w_rem;
  logic [GB_W-1:0]          w_take;
  logic [GB_W-1:0]          w_used_next;
  logic [GS_W:0]            w_beat_next;
  logic                     w_end;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W-1:0]  w_coe_ext;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [SW-1:0]     w_sum;
  logic signed [ACC_W-1:0]  w_acc_new;
  logic signed [ACC_W-1:0]  w_res;

  // In IDLE the incoming beat is the first of a group, so live config applies.
  always_comb begin
    w_idle      = (r_state == IDLE);
    w_dt        = w_idle ? DT_W'(clamp_data_terms(32'(cfg_data_terms), NUM_TERMS)) : r_dt;
    w_gs        = w_idle ? ((cfg_group_size == '0) ? GS_W'(1) : cfg_group_size) : r_gs;
    w_gb        = w_idle ? cfg_group_budget : r_gb;
    w_used      = w_idle ? '0 : r_used;
    w_acc       = w_idle ? '0 : r_acc;
    w_beat_next = (w_idle ? '0 : {1'b0, r_beat}) + (GS_W+1)'(1);
    w_end       = (w_beat_next >= {1'b0, w_gs});
    w_rem       = w_gb - w_used;
    w_coe_ext   = ACC_W'(r_coe);
    w_term      = '0;
    w_sum       = '0;
    w_take      = '0;
    for (int j = 0; j < NUM_TERMS; j++) begin
      w_term = ACC_W'(w_coe_ext <<< exp_in[j*EXP_W +: EXP_W]);
      if (sign_in[j]) w_term = -w_term;
      if ((DT_W'(j) < w_dt) && (w_take < w_rem)) begin
        w_sum  = w_sum + SW'(w_term);
        w_take = w_take + GB_W'(1);
      end
    end
    w_used_next = w_used + w_take;
    w_acc_new   = fit(SW'(w_acc) + w_sum);
    w_res       = fit(SW'(acc_in) + SW'(w_acc_new));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_coe        <= '0;
      r_acc        <= '0;
      r_beat       <= '0;
      r_used       <= '0;
      r_dt         <= '0;
      r_gs         <= '0;
      r_gb         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (coe_load) r_coe <= coe_in;
      if (in_valid) begin
        if (w_idle) begin
          r_dt <= w_dt;
          r_gs <= w_gs;
          r_gb <= w_gb;
        end
        if (w_end) begin
          result       <= w_res;
          result_valid <= 1'b1;
          r_acc        <= '0;
          r_beat       <= '0;
          r_used       <= '0;
          r_state      <= IDLE;
        end else begin
          r_acc   <= w_acc_new;
          r_beat  <= w_beat_next[GS_W-1:0];
          r_used  <= w_used_next;
          r_state <= ACC;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tq_mac_row.sv
// ============================================================================
// Module   : tq_mac_row
// Purpose  : Row of NUM_LANE term-quantized MAC lanes fed by a systolic skew
//            chain; the skewed term stream is forwarded for row chaining.
// Options  : TQ_MAC_ROW_SATURATE_EN - saturating lane adds (default: wrap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tq_mac_row #(
  parameter int NUM_LANE  = 8,
  parameter int NUM_TERMS = 8,
  parameter int EXP_W     = 3,
  parameter int COE_W     = 8,
  parameter int ACC_W     = 16,
  parameter int GS_W      = 5,
  parameter int GB_W      = 7,
  parameter int DT_W      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DT_W-1:0]               cfg_data_terms,
  input  logic [GS_W-1:0]               cfg_group_size,
  input  logic [GB_W-1:0]               cfg_group_budget,
  input  logic [NUM_LANE*COE_W-1:0]     coe_in,
  input  logic                          coe_load,
  input  logic [NUM_LANE*ACC_W-1:0]     acc_in,
  input  logic                          in_valid,
  input  logic [NUM_TERMS*EXP_W-1:0]    exp_in,
  input  logic [NUM_TERMS-1:0]          sign_in,
  output logic                          fwd_valid,
  output logic [NUM_TERMS*EXP_W-1:0]    exp_out,
  output logic [NUM_TERMS-1:0]          sign_out,
  output logic [NUM_LANE*ACC_W-1:0]     result,
  output logic [NUM_LANE-1:0]           result_valid
);

  logic                          r_vld [NUM_LANE];
  logic [NUM_TERMS*EXP_W-1:0]    r_exp [NUM_LANE];
  logic [NUM_TERMS-1:0]          r_sgn [NUM_LANE];

  // Stage k feeds lane k, so lane k sees a beat k+1 cycles after entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_LANE; k++) begin
        r_vld[k] <= 1'b0;
        r_exp[k] <= '0;
        r_sgn[k] <= '0;
      end
    end else begin
      r_vld[0] <= in_valid;
      r_exp[0] <= exp_in;
      r_sgn[0] <= sign_in;
      for (int k = 1; k < NUM_LANE; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_exp[k] <= r_exp[k-1];
        r_sgn[k] <= r_sgn[k-1];
      end
    end
  end

  assign fwd_valid = r_vld[NUM_LANE-1];
  assign exp_out   = r_exp[NUM_LANE-1];
  assign sign_out  = r_sgn[NUM_LANE-1];

  generate
    for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
      tq_mac_lane #(
        .NUM_TERMS (NUM_TERMS),
        .EXP_W     (EXP_W),
        .COE_W     (COE_W),
        .ACC_W     (ACC_W),
        .GS_W      (GS_W),
        .GB_W      (GB_W),
        .DT_W      (DT_W)
      ) u_lane (
        .clk              (clk),
        .reset            (reset),
        .cfg_data_terms   (cfg_data_terms),
        .cfg_group_size   (cfg_group_size),
        .cfg_group_budget (cfg_group_budget),
        .coe_in           (coe_in[i*COE_W +: COE_W]),
        .coe_load         (coe_load),
        .acc_in           (acc_in[i*ACC_W +: ACC_W]),
        .in_valid         (r_vld[i]),
        .exp_in           (r_exp[i]),
        .sign_in          (r_sgn[i]),
        .result           (result[i*ACC_W +: ACC_W]),
        .result_valid     (result_valid[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_tq_mac_row.sv
// ============================================================================
// Module   : tb_tq_mac_row
// Purpose  : Scoreboard bench for tq_mac_row (4 lanes, 8-bit accumulators).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tq_mac_row;

  localparam int NL = 4, NT = 8, EW = 3, CW = 8, AW = 8, GSW = 5, GBW = 7, DTW = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [DTW-1:0]       cfg_data_terms = '0;
  logic [GSW-1:0]       cfg_group_size = '0;
  logic [GBW-1:0]       cfg_group_budget = '0;
  logic [NL*CW-1:0]     coe_in = '0;
  logic                 coe_load = 1'b0;
  logic [NL*AW-1:0]     acc_in = '0;
  logic                 in_valid = 1'b0;
  logic [NT*EW-1:0]     exp_in = '0;
  logic [NT-1:0]        sign_in = '0;
  logic                 fwd_valid;
  logic [NT*EW-1:0]     exp_out;
  logic [NT-1:0]        sign_out;
  logic [NL*AW-1:0]     result;
  logic [NL-1:0]        result_valid;

  always #5 clk = ~clk;

  tq_mac_row #(
    .NUM_LANE(NL), .NUM_TERMS(NT), .EXP_W(EW), .COE_W(CW),
    .ACC_W(AW), .GS_W(GSW), .GB_W(GBW), .DT_W(DTW)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_data_terms(cfg_data_terms), .cfg_group_size(cfg_group_size),
    .cfg_group_budget(cfg_group_budget),
    .coe_in(coe_in), .coe_load(coe_load), .acc_in(acc_in),
    .in_valid(in_valid), .exp_in(exp_in), .sign_in(sign_in),
    .fwd_valid(fwd_valid), .exp_out(exp_out), .sign_out(sign_out),
    .result(result), .result_valid(result_valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct { int val; int cyc; } res_t;
  typedef struct { logic [NT*EW-1:0] e; logic [NT-1:0] s; int cyc; } fwd_t;
  res_t sb_q [NL][$];
  fwd_t fwd_q [$];

  // Reference lane model, advanced at the moment a beat is driven.
  int m_coe [NL], m_accin [NL], m_acc [NL], m_used [NL], m_beat [NL];
  int m_dt [NL], m_gs [NL], m_gb [NL];
  bit m_busy [NL];

  function automatic int wrapw(input int v);
    int m;
    m = v & ((1 << AW) - 1);
    if (m >= (1 << (AW - 1))) m -= (1 << AW);
    return m;
  endfunction

  function automatic int fit(input int v);
`ifdef TQ_MAC_ROW_SATURATE_EN
    if (v > (1 << (AW - 1)) - 1) return (1 << (AW - 1)) - 1;
    if (v < -(1 << (AW - 1)))    return -(1 << (AW - 1));
    return v;
`else
    return wrapw(v);
`endif
  endfunction

  task automatic model_beat(input logic [NT*EW-1:0] e, input logic [NT-1:0] s);
    int rem, bsum, t;
    res_t r;
    for (int l = 0; l < NL; l++) begin
      if (!m_busy[l]) begin
        m_dt[l]   = (int'(cfg_data_terms) > NT) ? NT : int'(cfg_data_terms);
        m_gs[l]   = (cfg_group_size == 0) ? 1 : int'(cfg_group_size);
        m_gb[l]   = int'(cfg_group_budget);
        m_acc[l]  = 0;
        m_used[l] = 0;
        m_beat[l] = 0;
        m_busy[l] = 1'b1;
      end
      rem  = m_gb[l] - m_used[l];
      bsum = 0;
      for (int j = 0; j < m_dt[l]; j++) begin
        if (rem > 0) begin
          t = wrapw(m_coe[l] * (1 << int'(e[j*EW +: EW])));
          if (s[j]) t = wrapw(-t);
          bsum += t;
          m_used[l]++;
          rem--;
        end
      end
      m_acc[l] = fit(m_acc[l] + bsum);
      m_beat[l]++;
      if (m_beat[l] >= m_gs[l]) begin
        r.val = fit(m_accin[l] + m_acc[l]);
        r.cyc = cyc + 2 + l;
        sb_q[l].push_back(r);
        m_busy[l] = 1'b0;
      end
    end
  endtask

  task automatic send(input bit v, input logic [NT*EW-1:0] e, input logic [NT-1:0] s);
    fwd_t f;
    @(posedge clk); #1;
    in_valid = v;
    exp_in   = e;
    sign_in  = s;
    if (v) begin
      model_beat(e, s);
      f.e = e; f.s = s; f.cyc = cyc + NL;
      fwd_q.push_back(f);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, '0, '0);
  endtask

  task automatic drain(input string tag);
    idle(NL + 4);
    for (int l = 0; l < NL; l++)
      check($sformatf("%s_pending_lane%0d", tag, l), sb_q[l].size(), 0);
    check($sformatf("%s_pending_fwd", tag), fwd_q.size(), 0);
  endtask

  task automatic load_coe(input int c [NL]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int l = 0; l < NL; l++) begin
      coe_in[l*CW +: CW] = CW'(c[l]);
      m_coe[l] = c[l];
    end
    coe_load = 1'b1;
    @(posedge clk); #1;
    coe_load = 1'b0;
  endtask

  task automatic set_accin(input int a [NL]);
    for (int l = 0; l < NL; l++) begin
      acc_in[l*AW +: AW] = AW'(a[l]);
      m_accin[l] = a[l];
    end
  endtask

  task automatic set_cfg(input int dt, input int gs, input int gb);
    cfg_data_terms   = DTW'(dt);
    cfg_group_size   = GSW'(gs);
    cfg_group_budget = GBW'(gb);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    fwd_q.delete();
    for (int l = 0; l < NL; l++) begin
      sb_q[l].delete();
      m_coe[l] = 0; m_acc[l] = 0; m_used[l] = 0; m_beat[l] = 0; m_busy[l] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_fwd_valid"}, int'(fwd_valid), 0);
    check({tag, "_exp_out"}, int'(exp_out), 0);
    check({tag, "_sign_out"}, int'(sign_out), 0);
  endtask

  always @(negedge clk) begin
    res_t r;
    fwd_t f;
    if (!reset) begin
      for (int l = 0; l < NL; l++) begin
        if (result_valid[l]) begin
          if (sb_q[l].size() == 0) begin
            check($sformatf("unexpected_pulse_lane%0d", l), 1, 0);
          end else begin
            r = sb_q[l].pop_front();
            check($sformatf("result_lane%0d", l), int'($signed(result[l*AW +: AW])), r.val);
            check($sformatf("pulse_cycle_lane%0d", l), cyc, r.cyc);
          end
        end else if (sb_q[l].size() > 0 && sb_q[l][0].cyc <= cyc) begin
          check($sformatf("missing_pulse_lane%0d", l), 0, 1);
          void'(sb_q[l].pop_front());
        end
      end
      if (fwd_valid) begin
        if (fwd_q.size() == 0) begin
          check("unexpected_fwd_valid", 1, 0);
        end else begin
          f = fwd_q.pop_front();
          check("fwd_exp", int'(exp_out), int'(f.e));
          check("fwd_sign", int'(sign_out), int'(f.s));
          check("fwd_cycle", cyc, f.cyc);
        end
      end else if (fwd_q.size() > 0 && fwd_q[0].cyc <= cyc) begin
        check("missing_fwd_valid", 0, 1);
        void'(fwd_q.pop_front());
      end
    end
  end

  localparam logic [NT*EW-1:0] ALL_EXP1 = 24'h249249;

  initial begin
    logic [NT*EW-1:0] e;
    logic [NT-1:0]    s;

    do_reset();
    @(negedge clk);
    check_zero("reset");

    // Basic single-beat group: 3 + (3<<2) = 15 on every lane, staggered.
    set_cfg(2, 1, 8);
    set_accin('{0, 0, 0, 0});
    load_coe('{3, 3, 3, 3});
    send(1'b1, 24'(2 << EW), '0);
    drain("basic");

    // Budget clipping across two beats: 4 + 1 accepted terms of value 2.
    set_cfg(4, 2, 5);
    load_coe('{1, 1, 1, 1});
    send(1'b1, ALL_EXP1, '0);
    send(1'b1, ALL_EXP1, '0);
    drain("budget");

    // Negative coefficient with negative sign plus partial sum.
    set_cfg(1, 1, 8);
    set_accin('{100, 100, 100, 100});
    load_coe('{-2, -2, -2, -2});
    send(1'b1, 24'(3), 8'h01);
    drain("signs");

    // Per-lane coefficients and partial sums, clamped data_terms, group_size 0.
    set_cfg(15, 0, 100);
    set_accin('{-20, -10, 0, 10});
    load_coe('{1, 2, 3, 4});
    send(1'b1, 24'h0a3c51, 8'b1010_0110);
    send(1'b1, 24'h1f0b27, 8'b0101_1001);
    drain("lanes");

    // Back-to-back groups separated by a bubble.
    set_cfg(1, 3, 20);
    set_accin('{5, 6, 7, 8});
    load_coe('{1, 1, 1, 1});
    repeat (3) send(1'b1, '0, '0);
    send(1'b0, '0, '0);
    repeat (3) send(1'b1, '0, '0);
    drain("b2b");

    // Zero budget: result is the partial sum alone.
    set_cfg(8, 2, 0);
    set_accin('{-3, 11, 42, -60});
    load_coe('{7, 7, 7, 7});
    send(1'b1, ALL_EXP1, '0);
    send(1'b1, ALL_EXP1, 8'hff);
    drain("budget0");

    // Overflow: 100 + 100 = 200 in an 8-bit accumulator.
    set_cfg(2, 1, 8);
    set_accin('{0, 0, 0, 0});
    load_coe('{100, 100, 100, 100});
    send(1'b1, '0, '0);
    drain("overflow");

    // Reset in the middle of a 4-beat group, then a clean group.
    set_cfg(2, 4, 8);
    set_accin('{1, 2, 3, 4});
    load_coe('{5, 5, 5, 5});
    send(1'b1, ALL_EXP1, '0);
    send(1'b1, ALL_EXP1, '0);
    do_reset();
    @(negedge clk);
    check_zero("midreset");
    load_coe('{2, 2, 2, 2});
    repeat (4) send(1'b1, 24'(1 | (2 << EW)), 8'h02);
    drain("postreset");

    // Random stream with bubbles under fixed config.
    set_cfg(5, 3, 9);
    set_accin('{-7, 13, 25, -40});
    load_coe('{3, -5, 9, -1});
    for (int n = 0; n < 40; n++) begin
      e = NT*EW'($urandom);
      s = NT'($urandom);
      send($urandom_range(0, 3) != 0, e, s);
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
